aes_stim_gen: RTL and testbench
===============================

AES_STIM_GEN -- requirements
Module: aes_stim_gen

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 1024, the WAIT_CT watchdog limit in clk cycles.
REQ-002 The module SHALL have port clk  input  1  clock, rising-edge active.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port start  input  1  single-cycle request to run a batch.
REQ-005 The module SHALL have port num_vec  input  16  number of vectors in the batch, sampled on the accepted start.
REQ-006 The module SHALL have port random128  input  128  free-running pseudo-random word from the upstream LFSR.
REQ-007 The module SHALL have port aes_key_o  output  128  key presented to the AES core.
REQ-008 The module SHALL have port aes_pt_o  output  128  plaintext presented to the AES core.
REQ-009 The module SHALL have port aes_valid_o  output  1  key and plaintext are valid.
REQ-010 The module SHALL have port aes_ready_i  input  1  AES core accepts the vector.
REQ-011 The module SHALL have port aes_ct_i  input  128  ciphertext from the AES core.
REQ-012 The module SHALL have port aes_ct_valid_i  input  1  aes_ct_i is valid, single-cycle.
REQ-013 The module SHALL have port busy_o  output  1  high when the state is not IDLE.
REQ-014 The module SHALL have port done_o  output  1  single-cycle pulse at batch end.
REQ-015 The module SHALL have port err_o  output  1  sticky watchdog timeout flag.
REQ-016 The module SHALL have port vec_cnt_o  output  16  number of ciphertexts completed in the current or last batch.
REQ-017 The module SHALL have port sig_o  output  128  XOR signature of all ciphertexts in the batch.

Function
REQ-018 The FSM SHALL have states IDLE, GET_KEY, GET_PT, SEND, WAIT_CT, FINISH.
REQ-019 In IDLE, start=1 SHALL latch num_vec and clear vec_cnt_o, sig_o, err_o and the watchdog count.
- num_vec!=0: next state GET_KEY.
- num_vec==0: next state FINISH.
REQ-020 A start arriving in any state other than IDLE SHALL be ignored, with no effect on the latched num_vec or the counters.
REQ-021 GET_KEY SHALL register random128 into aes_key_o and go to GET_PT on the next cycle.
REQ-022 GET_PT SHALL register random128 into aes_pt_o, so the key and plaintext come from consecutive LFSR words, and go to SEND.
REQ-023 In SEND, aes_valid_o SHALL be 1 and aes_key_o/aes_pt_o SHALL stay stable until aes_ready_i=1.
REQ-024 The cycle with aes_valid_o=1 and aes_ready_i=1 SHALL be the handshake cycle; the next state SHALL be WAIT_CT and aes_valid_o SHALL drop on the following cycle.
REQ-025 aes_valid_o SHALL be 0 in every state except SEND.
REQ-026 In WAIT_CT, aes_ct_valid_i=1 SHALL update sig_o to sig_o XOR aes_ct_i, increment vec_cnt_o by 1 and clear the watchdog.
- vec_cnt_o+1 equal to the latched num_vec: next state FINISH.
- Otherwise: next state GET_KEY.
REQ-027 aes_ct_valid_i outside WAIT_CT SHALL be ignored.
REQ-028 In WAIT_CT, the watchdog SHALL increment every cycle with no aes_ct_valid_i.
- On reaching TIMEOUT, err_o SHALL be set and the next state SHALL be FINISH.
- vec_cnt_o and sig_o SHALL not change on timeout.
REQ-029 If aes_ct_valid_i arrives in the same cycle the watchdog reaches TIMEOUT, the ciphertext SHALL be taken and err_o SHALL stay 0.
REQ-030 FINISH SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-031 vec_cnt_o, sig_o and err_o SHALL hold their values in IDLE until the next accepted start.
REQ-032 vec_cnt_o SHALL be 16-bit; num_vec=65535 SHALL complete 65535 vectors without wrapping.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE and every output SHALL be 0.
- aes_key_o, aes_pt_o, sig_o, vec_cnt_o.
- aes_valid_o, busy_o, done_o, err_o.
REQ-034 Reset asserted mid-batch SHALL abort the batch immediately, with no done_o pulse and no pending handshake.
REQ-035 After rst_n deasserts, the block SHALL stay IDLE until the next start.

Verification
REQ-036 Basic batch: num_vec=3, aes_ready_i tied 1, ciphertext returned 5 cycles after each handshake -> 3 handshakes, vec_cnt_o=3, sig_o=ct0^ct1^ct2, one done_o pulse, err_o=0.
REQ-037 Backpressure: aes_ready_i held 0 for 7 cycles in SEND -> aes_valid_o stays 1 and key/pt stay unchanged for all 7 cycles; the handshake completes on the first cycle with aes_ready_i=1.
REQ-038 Key/pt source: random128 driven as an incrementing counter N -> the next key captured is N and the plaintext is N+1.
REQ-039 Zero batch: start with num_vec=0 -> done_o pulses 2 cycles after start, no aes_valid_o, vec_cnt_o=0.
REQ-040 Timeout: with TIMEOUT=16, aes_ct_valid_i is never returned -> err_o=1 and done_o pulse after 16 WAIT_CT cycles, vec_cnt_o=0; a further start clears err_o.
REQ-041 Abort and ignored start: rst_n pulsed low during WAIT_CT -> all outputs 0, busy_o=0; start asserted during SEND -> ignored and the batch count is unchanged.

Source files
------------

// File: rtl/aes_stim_gen_if.sv
// Request/response bus between the stimulus generator (master) and the AES core (slave).
interface aes_stim_gen_if;
  logic [127:0] aes_key_o;
  logic [127:0] aes_pt_o;
  logic         aes_valid_o;
  logic         aes_ready_i;
  logic [127:0] aes_ct_i;
  logic         aes_ct_valid_i;

  modport master (
    output aes_key_o,
    output aes_pt_o,
    output aes_valid_o,
    input  aes_ready_i,
    input  aes_ct_i,
    input  aes_ct_valid_i
  );

  modport slave (
    input  aes_key_o,
    input  aes_pt_o,
    input  aes_valid_o,
    output aes_ready_i,
    output aes_ct_i,
    output aes_ct_valid_i
  );
endinterface

// File: rtl/aes_stim_gen.sv
// Drives batches of random key/plaintext vectors into an AES core and folds the returned
// ciphertexts into an XOR signature, with a per-vector watchdog on the AES response.
module aes_stim_gen #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [15:0]           num_vec,
  input  logic [127:0]          random128,
  aes_stim_gen_if.master        aes,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [15:0]           vec_cnt_o,
  output logic [127:0]          sig_o
);

  localparam int unsigned     WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_KEY = 3'd1,
    GET_PT  = 3'd2,
    SEND    = 3'd3,
    WAIT_CT = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e          state_q;
  logic [15:0]     num_q;
  logic [15:0]     cnt_q;
  logic [127:0]    sig_q;
  logic [127:0]    key_q;
  logic [127:0]    pt_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [WD_W-1:0] wdog_q;
  logic [15:0]     cnt_inc_s;

  assign cnt_inc_s = cnt_q + 16'd1;

  // Batch sequencer: state, AES request registers, accumulators and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= 16'd0;
      cnt_q   <= 16'd0;
      sig_q   <= 128'd0;
      key_q   <= 128'd0;
      pt_q    <= 128'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_q   <= num_vec;
            cnt_q   <= 16'd0;
            sig_q   <= 128'd0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= (num_vec != 16'd0) ? GET_KEY : FINISH;
          end else begin
            state_q <= IDLE;
          end
        end
        GET_KEY: begin
          key_q   <= random128;
          state_q <= GET_PT;
        end
        // valid rises together with the plaintext so the request is complete when seen
        GET_PT: begin
          pt_q    <= random128;
          valid_q <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          if (aes.aes_ready_i) begin
            valid_q <= 1'b0;
            wdog_q  <= '0;
            state_q <= WAIT_CT;
          end else begin
            state_q <= SEND;
          end
        end
        // A ciphertext arriving on the last watchdog cycle wins over the timeout
        WAIT_CT: begin
          if (aes.aes_ct_valid_i) begin
            sig_q   <= sig_q ^ aes.aes_ct_i;
            cnt_q   <= cnt_inc_s;
            wdog_q  <= '0;
            state_q <= (cnt_inc_s == num_q) ? FINISH : GET_KEY;
          end else if (wdog_q == WD_LAST) begin
            err_q   <= 1'b1;
            state_q <= FINISH;
          end else begin
            wdog_q  <= wdog_q + WD_ONE;
          end
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign aes.aes_key_o   = key_q;
  assign aes.aes_pt_o    = pt_q;
  assign aes.aes_valid_o = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign vec_cnt_o       = cnt_q;
  assign sig_o           = sig_q;

endmodule

// File: tb/tb_aes_stim_gen.sv
// Directed bench for aes_stim_gen: batches, backpressure, zero batch, watchdog and abort.
module tb_aes_stim_gen;

  localparam logic [127:0] KEY_N  = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3C;
  localparam logic [127:0] PT_N   = 128'h2B7E_1516_28AE_D2A6_ABF7_1588_09CF_4F3D;
  localparam logic [127:0] BP_K   = 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF;
  localparam logic [127:0] BP_P   = 128'h0000_0000_0000_0000_0000_0001_0000_0000;
  localparam logic [127:0] SIG3   = 128'h9111_1111_1111_1111_1111_1111_1111_11EE;
  localparam logic [127:0] CT3    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] CT4    = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
  localparam logic [127:0] CT5    = 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  num_vec;
  logic [127:0] random128;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [15:0]  vec_cnt_o;
  logic [127:0] sig_o;

  aes_stim_gen_if bus();

  int n_checks  = 0;
  int n_errors  = 0;
  int hs_cnt    = 0;
  int done_cnt  = 0;
  int valid_cnt = 0;
  int ct_idx    = 0;
  int ct_delay  = 0;
  logic ct_en;
  int   ct_dly;

  always #5 clk = ~clk;

  aes_stim_gen #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .random128 (random128),
    .aes       (bus.master),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .vec_cnt_o (vec_cnt_o),
    .sig_o     (sig_o)
  );

  function automatic logic [127:0] ct_val(input int idx);
    case (idx)
      0:       ct_val = 128'h0000_0000_0000_0000_0000_0000_0000_00F0;
      1:       ct_val = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
      2:       ct_val = 128'h8000_0000_0000_0000_0000_0000_0000_000F;
      3:       ct_val = CT3;
      4:       ct_val = CT4;
      default: ct_val = CT5;
    endcase
  endfunction

  // AES core model: returns the next ciphertext ct_dly cycles after each handshake
  always @(negedge clk) begin
    bus.aes_ct_valid_i = 1'b0;
    if (ct_delay != 0) begin
      ct_delay = ct_delay - 1;
      if (ct_delay == 0) begin
        bus.aes_ct_valid_i = 1'b1;
        bus.aes_ct_i       = ct_val(ct_idx);
        ct_idx             = ct_idx + 1;
      end
    end
    if (bus.aes_valid_o && bus.aes_ready_i) begin
      hs_cnt = hs_cnt + 1;
      if (ct_en) ct_delay = ct_dly;
    end
    if (bus.aes_valid_o) valid_cnt = valid_cnt + 1;
    if (done_o) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_o !== 1'b1 && n < 300) begin
      tick();
      n = n + 1;
    end
    check(tag, 128'(done_o), 128'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"},   bus.aes_key_o, 128'd0);
    check({tag, "_pt"},    bus.aes_pt_o, 128'd0);
    check({tag, "_sig"},   sig_o, 128'd0);
    check({tag, "_cnt"},   128'(vec_cnt_o), 128'd0);
    check({tag, "_valid"}, 128'(bus.aes_valid_o), 128'd0);
    check({tag, "_busy"},  128'(busy_o), 128'd0);
    check({tag, "_done"},  128'(done_o), 128'd0);
    check({tag, "_err"},   128'(err_o), 128'd0);
  endtask

  initial begin
    int hs0;
    int dn0;
    int v0;
    logic early_err;

    rst_n = 1'b0; start = 1'b0; num_vec = 16'd0; random128 = 128'd0;
    bus.aes_ready_i = 1'b0; ct_en = 1'b1; ct_dly = 5;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_after_rst", 128'(busy_o), 128'd0);

    // Basic batch of three, key/pt from consecutive words
    hs0 = hs_cnt; dn0 = done_cnt;
    bus.aes_ready_i = 1'b1;
    num_vec = 16'd3; start = 1'b1; random128 = KEY_N;
    tick();
    start = 1'b0; num_vec = 16'd0;
    check("basic_busy", 128'(busy_o), 128'd1);
    tick();
    check("key_is_n", bus.aes_key_o, KEY_N);
    random128 = PT_N;
    tick();
    check("pt_is_n1", bus.aes_pt_o, PT_N);
    check("valid_in_send", 128'(bus.aes_valid_o), 128'd1);
    random128 = 128'hDEAD;
    wait_done("basic_done");
    check("basic_cnt", 128'(vec_cnt_o), 128'd3);
    check("basic_sig", sig_o, SIG3);
    check("basic_err", 128'(err_o), 128'd0);
    tick();
    check("basic_hs", 128'(hs_cnt - hs0), 128'd3);
    check("basic_done_once", 128'(done_cnt - dn0), 128'd1);
    check("basic_idle", 128'(busy_o), 128'd0);
    check("basic_hold_cnt", 128'(vec_cnt_o), 128'd3);

    // Backpressure for 7 cycles, with an ignored start in SEND
    bus.aes_ready_i = 1'b0;
    num_vec = 16'd1; start = 1'b1; random128 = BP_K;
    tick();
    start = 1'b0;
    tick();
    random128 = BP_P;
    tick();
    hs0 = hs_cnt;
    for (int i = 0; i < 7; i++) begin
      random128 = 128'(i) ^ 128'h1234_5678;
      start     = (i == 3);
      num_vec   = (i == 3) ? 16'd5 : 16'd1;
      check("bp_valid", 128'(bus.aes_valid_o), 128'd1);
      check("bp_key", bus.aes_key_o, BP_K);
      check("bp_pt", bus.aes_pt_o, BP_P);
      tick();
    end
    start = 1'b0;
    check("bp_no_hs", 128'(hs_cnt - hs0), 128'd0);
    bus.aes_ready_i = 1'b1;
    tick();
    check("bp_valid_drop", 128'(bus.aes_valid_o), 128'd0);
    check("bp_hs_once", 128'(hs_cnt - hs0), 128'd1);
    wait_done("bp_done");
    check("bp_cnt", 128'(vec_cnt_o), 128'd1);
    check("bp_sig", sig_o, CT3);
    tick();

    // Zero-length batch
    v0 = valid_cnt;
    num_vec = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_not_yet", 128'(done_o), 128'd0);
    tick();
    check("zero_done", 128'(done_o), 128'd1);
    check("zero_cnt", 128'(vec_cnt_o), 128'd0);
    check("zero_sig", sig_o, 128'd0);
    tick();
    check("zero_single", 128'(done_o), 128'd0);
    check("zero_no_valid", 128'(valid_cnt - v0), 128'd0);

    // Watchdog timeout after 16 WAIT_CT cycles
    ct_en = 1'b0;
    num_vec = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("to_wait_busy", 128'(busy_o), 128'd1);
    check("to_wait_valid", 128'(bus.aes_valid_o), 128'd0);
    early_err = 1'b0;
    repeat (15) begin
      tick();
      early_err = early_err | err_o;
    end
    check("to_no_early_err", 128'(early_err), 128'd0);
    tick();
    check("to_err", 128'(err_o), 128'd1);
    check("to_done_not_yet", 128'(done_o), 128'd0);
    tick();
    check("to_done", 128'(done_o), 128'd1);
    check("to_cnt", 128'(vec_cnt_o), 128'd0);
    tick();
    check("to_err_sticky", 128'(err_o), 128'd1);
    ct_en = 1'b1;
    num_vec = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("to_err_cleared", 128'(err_o), 128'd0);
    wait_done("after_to_done");
    check("after_to_sig", sig_o, CT4);
    tick();

    // Ciphertext on the very last watchdog cycle is taken
    ct_dly = 16;
    num_vec = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("edge_done");
    check("edge_err", 128'(err_o), 128'd0);
    check("edge_cnt", 128'(vec_cnt_o), 128'd1);
    check("edge_sig", sig_o, CT5);
    tick();

    // Reset during WAIT_CT aborts the batch
    ct_en = 1'b0; ct_dly = 5;
    num_vec = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_busy_before", 128'(busy_o), 128'd1);
    dn0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_idle", 128'(busy_o), 128'd0);
    check("abort_no_done", 128'(done_cnt - dn0), 128'd0);
    check("abort_no_valid", 128'(bus.aes_valid_o), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
